// File: rtl/demux4_deser.sv
// Receive-side 4-lane de-multiplexer: serial beats u,v,w,x -> registered parallel lanes.
// Define DEMUX_PARITY_EN to add a 5th even-parity beat per frame (sel widens to 3 bits).
module demux4_deser #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] u,
    output logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] x,
`ifdef DEMUX_PARITY_EN
    output logic [2:0]       sel,
`else
    output logic [1:0]       sel,
`endif
    output logic             frame_valid,
    output logic             frame_err
);

    // state | meaning
    // HUNT  | waiting for an accepted sync beat to find frame start
    // RUN   | aligned; collecting lane beats into the shadow registers

`ifdef DEMUX_PARITY_EN
    localparam int SEL_W = 3;
    localparam int NSH   = 4;
`else
    localparam int SEL_W = 2;
    localparam int NSH   = 3;
`endif
    // sel value of the beat that completes a frame (x, or parity when enabled)
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NSH);

    typedef enum logic {HUNT, RUN} state_t;

    state_t           state_q, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [WIDTH-1:0] shadow_q [NSH];
    logic             sh_we;
    logic [SEL_W-1:0] sh_idx;
    logic             load;
    logic             fv_n;
    logic             fe_n;

`ifdef DEMUX_PARITY_EN
    logic par_ok;
    assign par_ok = (din == (shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3]));
`endif

    always_comb begin
        state_n = state_q;
        sel_n   = sel;
        sh_we   = 1'b0;
        sh_idx  = sel;
        load    = 1'b0;
        fv_n    = 1'b0;
        fe_n    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        sh_we   = 1'b1;
                        sh_idx  = '0;
                        sel_n   = SEL_W'(1);
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (sync && (sel != '0)) begin
                        // misaligned sync: drop the partial frame, restart at lane u
                        fe_n   = 1'b1;
                        sh_we  = 1'b1;
                        sh_idx = '0;
                        sel_n  = SEL_W'(1);
                    end else if (sel == LAST) begin
                        sel_n = '0;
`ifdef DEMUX_PARITY_EN
                        load  = par_ok;
                        fv_n  = par_ok;
                        fe_n  = !par_ok;
`else
                        load  = 1'b1;
                        fv_n  = 1'b1;
`endif
                    end else begin
                        sh_we = 1'b1;
                        sel_n = sel + 1'b1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HUNT;
            sel         <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            u           <= '0;
            v           <= '0;
            w           <= '0;
            x           <= '0;
            for (int i = 0; i < NSH; i++) shadow_q[i] <= '0;
        end else begin
            state_q     <= state_n;
            sel         <= sel_n;
            frame_valid <= fv_n;
            frame_err   <= fe_n;
            for (int i = 0; i < NSH; i++) begin
                if (sh_we && (sh_idx == SEL_W'(i))) shadow_q[i] <= din;
            end
            if (load) begin
                u <= shadow_q[0];
                v <= shadow_q[1];
                w <= shadow_q[2];
`ifdef DEMUX_PARITY_EN
                x <= shadow_q[3];
`else
                x <= din;
`endif
            end
        end
    end

endmodule

// File: tb/tb_demux4_deser.sv
// Self-checking bench for demux4_deser (WIDTH=4); follows DEMUX_PARITY_EN if defined.
module tb_demux4_deser;

`ifdef DEMUX_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       din_valid;
    logic       sync;
    logic [3:0] u, v, w, x;
`ifdef DEMUX_PARITY_EN
    logic [2:0] sel;
`else
    logic [1:0] sel;
`endif
    logic       frame_valid;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    demux4_deser #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
        .u(u), .v(v), .w(w), .x(x), .sel(sel),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a list of beats collected since frame start, committed when it holds NB beats.
    logic [3:0] m_out [4] = '{default: 4'h0};
    logic [3:0] m_buf [NB];
    int         m_cnt  = 0;
    bit         m_hunt = 1'b1;
    bit         m_fv   = 1'b0;
    bit         m_fe   = 1'b0;

    always @(posedge clock) begin
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (reset) begin
            m_out  = '{default: 4'h0};
            m_cnt  = 0;
            m_hunt = 1'b1;
        end else if (din_valid) begin
            if (m_hunt) begin
                if (sync) begin
                    m_buf[0] = din;
                    m_cnt    = 1;
                    m_hunt   = 1'b0;
                end
            end else if (sync && m_cnt != 0) begin
                m_fe     = 1'b1;
                m_buf[0] = din;
                m_cnt    = 1;
            end else begin
                m_buf[m_cnt] = din;
                m_cnt++;
                if (m_cnt == NB) begin
                    m_cnt = 0;
                    if (NB == 4 || m_buf[NB-1] == (m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3])) begin
                        for (int i = 0; i < 4; i++) m_out[i] = m_buf[i];
                        m_fv = 1'b1;
                    end else begin
                        m_fe = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("u", int'(u), int'(m_out[0]));
            chk("v", int'(v), int'(m_out[1]));
            chk("w", int'(w), int'(m_out[2]));
            chk("x", int'(x), int'(m_out[3]));
            chk("sel", int'(sel), m_cnt);
            chk("frame_valid", int'(frame_valid), int'(m_fv));
            chk("frame_err", int'(frame_err), int'(m_fe));
        end
    end

    task automatic beat(input logic s, input logic [3:0] d);
        din_valid = 1'b1;
        sync      = s;
        din       = d;
        @(negedge clock);
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic frame(input logic [3:0] a, b, c, d, input logic s0);
        beat(s0, a);
        beat(1'b0, b);
        beat(1'b0, c);
        beat(1'b0, d);
`ifdef DEMUX_PARITY_EN
        beat(1'b0, a ^ b ^ c ^ d);
`endif
    endtask

    task automatic lit_out(input string tag, input logic [3:0] a, b, c, d);
        chk({tag, "_u"}, int'(u), int'(a));
        chk({tag, "_v"}, int'(v), int'(b));
        chk({tag, "_w"}, int'(w), int'(c));
        chk({tag, "_x"}, int'(x), int'(d));
    endtask

    initial begin
        reset = 1'b1; din_valid = 1'b0; sync = 1'b0; din = 4'h0;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        lit_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_fv", int'(frame_valid), 0);

        // single-bit lane pattern 1,0,1,1
        frame(4'h1, 4'h0, 4'h1, 4'h1, 1'b1);
        lit_out("f1", 4'h1, 4'h0, 4'h1, 4'h1);
        chk("f1_fv", int'(frame_valid), 1);
        chk("f1_sel", int'(sel), 0);
        idle(1);
        chk("f1_fv_drop", int'(frame_valid), 0);

        // frame A,5,C,3 then frame B with an idle gap mid-frame
        frame(4'hA, 4'h5, 4'hC, 4'h3, 1'b1);
        lit_out("fa", 4'hA, 4'h5, 4'hC, 4'h3);
        beat(1'b1, 4'hB);
        beat(1'b0, 4'h1);
        idle(2);
        lit_out("gap_hold", 4'hA, 4'h5, 4'hC, 4'h3);
        chk("gap_sel", int'(sel), 2);
        chk("gap_fv", int'(frame_valid), 0);
        beat(1'b0, 4'h2);
        beat(1'b0, 4'h3);
`ifdef DEMUX_PARITY_EN
        beat(1'b0, 4'hB ^ 4'h1 ^ 4'h2 ^ 4'h3);
`endif
        lit_out("fb", 4'hB, 4'h1, 4'h2, 4'h3);
        chk("fb_fv", int'(frame_valid), 1);

        // beats before first sync are ignored
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        beat(1'b0, 4'hF); beat(1'b0, 4'hF); beat(1'b0, 4'hF);
        chk("hunt_sel", int'(sel), 0);
        lit_out("hunt", 4'h0, 4'h0, 4'h0, 4'h0);
        frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        lit_out("f1234", 4'h1, 4'h2, 4'h3, 4'h4);

        // misaligned sync at sel=2
        beat(1'b1, 4'hD);
        beat(1'b0, 4'hE);
        chk("mis_sel_pre", int'(sel), 2);
        beat(1'b1, 4'h9);
        chk("mis_fe", int'(frame_err), 1);
        chk("mis_fv", int'(frame_valid), 0);
        chk("mis_sel", int'(sel), 1);
        lit_out("mis_hold", 4'h1, 4'h2, 4'h3, 4'h4);
        beat(1'b0, 4'h8);
        beat(1'b0, 4'h7);
        beat(1'b0, 4'h6);
`ifdef DEMUX_PARITY_EN
        beat(1'b0, 4'h9 ^ 4'h8 ^ 4'h7 ^ 4'h6);
`endif
        lit_out("f9876", 4'h9, 4'h8, 4'h7, 4'h6);
        chk("f9876_fv", int'(frame_valid), 1);
        chk("f9876_fe", int'(frame_err), 0);

        // back-to-back frames, second without sync on lane u
        frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        frame(4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
        lit_out("b2b", 4'h5, 4'h6, 4'h7, 4'h8);
        chk("b2b_fv", int'(frame_valid), 1);

        // reset at sel=3 mid-frame
        beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h3);
        chk("rst_mid_sel_pre", int'(sel), 3);
        reset = 1'b1;
        @(negedge clock);
        lit_out("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_mid_sel", int'(sel), 0);
        chk("rst_mid_fv", int'(frame_valid), 0);
        chk("rst_mid_fe", int'(frame_err), 0);
        reset = 1'b0;
        beat(1'b0, 4'h5);
        chk("rst_mid_hunt", int'(sel), 0);
        beat(1'b1, 4'h5);
        chk("rst_mid_sync", int'(sel), 1);
        beat(1'b0, 4'h6); beat(1'b0, 4'h7); beat(1'b0, 4'h8);
`ifdef DEMUX_PARITY_EN
        beat(1'b0, 4'h5 ^ 4'h6 ^ 4'h7 ^ 4'h8);
`endif
        lit_out("after_rst", 4'h5, 4'h6, 4'h7, 4'h8);

`ifdef DEMUX_PARITY_EN
        frame(4'h1, 4'h2, 4'h4, 4'h8, 1'b1);
        lit_out("par_ok", 4'h1, 4'h2, 4'h4, 4'h8);
        chk("par_ok_fv", int'(frame_valid), 1);
        frame(4'h3, 4'h3, 4'h3, 4'h3, 1'b1);
        beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h4); beat(1'b0, 4'h8);
        chk("par_sel4", int'(sel), 4);
        beat(1'b0, 4'hE);
        chk("par_bad_fe", int'(frame_err), 1);
        chk("par_bad_fv", int'(frame_valid), 0);
        chk("par_bad_sel", int'(sel), 0);
        lit_out("par_bad_hold", 4'h3, 4'h3, 4'h3, 4'h3);
`endif

        idle(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
